pe_feeder: RTL and testbench

- Command-driven operand feeder for one systolic processing element (PE).
- Reads paired A/B operand vectors from a single-port data RAM and writes them into the PE's A and B input FIFOs, honouring the FIFO-full flags.
- Once all operands are pushed, it programs the element count, pulses start, and waits for the PE's finish flag.
- Sits between the command/CSR path and the PE; it is the writer side of the PE's a/b load interface.

---
 rtl/pe_pkg.sv | 34 +++
 rtl/pe_feeder.sv | 111 +++++++++++
 tb/tb_pe_feeder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the processing element and its feeder.
// Holds the default operand/address/count widths and the feeder state encoding.
// Ports: none (package).
package pe_pkg;

  localparam int PE_DW = 16;  // operand data width
  localparam int PE_AW = 12;  // RAM word-address width
  localparam int PE_CW = 8;   // element-count width

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_RD_A   = 4'd1;
  localparam logic [3:0] ST_LAT_A  = 4'd2;
  localparam logic [3:0] ST_PUSH_A = 4'd3;
  localparam logic [3:0] ST_RD_B   = 4'd4;
  localparam logic [3:0] ST_LAT_B  = 4'd5;
  localparam logic [3:0] ST_PUSH_B = 4'd6;
  localparam logic [3:0] ST_START  = 4'd7;
  localparam logic [3:0] ST_WAIT_F = 4'd8;
  localparam logic [3:0] ST_DONE   = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE   = ST_IDLE,
    S_RD_A   = ST_RD_A,
    S_LAT_A  = ST_LAT_A,
    S_PUSH_A = ST_PUSH_A,
    S_RD_B   = ST_RD_B,
    S_LAT_B  = ST_LAT_B,
    S_PUSH_B = ST_PUSH_B,
    S_START  = ST_START,
    S_WAIT_F = ST_WAIT_F,
    S_DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/pe_feeder.sv
// Operand feeder for one systolic PE: reads A[i]/B[i] pairs from a single-port RAM,
// pushes them into the PE A/B FIFOs (honouring full flags), then starts the PE and
// waits for its finish flag. 6 cycles per element unstalled; stalls in PUSH states.
// Ports: cmd_* command handshake, mem_* RAM read port, pe_* PE load/control, busy/done status.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int DW = PE_DW,
  parameter int AW = PE_AW,
  parameter int CW = PE_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_a_base,
  input  logic [AW-1:0] cmd_b_base,
  input  logic [CW-1:0] cmd_len,
  output logic          mem_ren,
  output logic [AW-1:0] mem_radr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pe_a,
  output logic [DW-1:0] pe_b,
  output logic          pe_awe,
  output logic          pe_bwe,
  input  logic          pe_aff,
  input  logic          pe_bff,
  output logic [CW-1:0] pe_max_cntr,
  output logic          pe_start,
  input  logic          pe_fout,
  output logic          busy,
  output logic          done
);

  state_t        state, state_nxt;
  logic [AW-1:0] a_base, b_base;
  logic [CW-1:0] idx;
  logic          accept;
  logic          last;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = (state == S_IDLE) && cmd_valid;
  // pe_max_cntr doubles as the latched length; len is never 0 when this is used.
  assign last      = (idx == pe_max_cntr - CW'(1));

  // Full flags are only looked at while a push is pending.
  assign pe_awe = (state == S_PUSH_A) && !pe_aff;
  assign pe_bwe = (state == S_PUSH_B) && !pe_bff;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_nxt = (cmd_len != '0) ? S_RD_A : S_DONE;
      S_RD_A:   state_nxt = S_LAT_A;
      S_LAT_A:  state_nxt = S_PUSH_A;
      S_PUSH_A: if (!pe_aff) state_nxt = S_RD_B;
      S_RD_B:   state_nxt = S_LAT_B;
      S_LAT_B:  state_nxt = S_PUSH_B;
      S_PUSH_B: if (!pe_bff) state_nxt = last ? S_START : S_RD_A;
      S_START:  state_nxt = S_WAIT_F;
      S_WAIT_F: if (pe_fout) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      a_base      <= '0;
      b_base      <= '0;
      idx         <= '0;
      pe_max_cntr <= '0;
      mem_ren     <= 1'b0;
      mem_radr    <= '0;
      pe_a        <= '0;
      pe_b        <= '0;
      pe_start    <= 1'b0;
      done        <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Strobes are decoded from the next state so they line up with the state itself.
      mem_ren  <= (state_nxt == S_RD_A) || (state_nxt == S_RD_B);
      pe_start <= (state_nxt == S_START);
      done     <= (state_nxt == S_DONE);

      if (accept) begin
        a_base      <= cmd_a_base;
        b_base      <= cmd_b_base;
        pe_max_cntr <= cmd_len;
        idx         <= '0;
      end

      if (state == S_PUSH_B && !pe_bff && !last) idx <= idx + CW'(1);

      // RD_A is entered either from IDLE (element 0, base not yet latched) or from
      // PUSH_B, where idx is about to advance; RD_B is always entered from PUSH_A.
      if (state_nxt == S_RD_A) begin
        if (state == S_IDLE) mem_radr <= cmd_a_base;
        else                 mem_radr <= a_base + AW'(idx + CW'(1));
      end else if (state_nxt == S_RD_B) begin
        mem_radr <= b_base + AW'(idx);
      end

      if (state == S_LAT_A) pe_a <= mem_rdata;
      if (state == S_LAT_B) pe_b <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: RAM model, PE finish responder, expected-traffic queues
// filled at command issue and drained by an output monitor.
// Ports: none.
module tb_pe_feeder;
  import pe_pkg::*;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int CW = 8;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_a_base, cmd_b_base;
  logic [CW-1:0] cmd_len;
  logic          mem_ren;
  logic [AW-1:0] mem_radr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pe_a, pe_b;
  logic          pe_awe, pe_bwe, pe_aff, pe_bff;
  logic [CW-1:0] pe_max_cntr;
  logic          pe_start, pe_fout, busy, done;

  pe_feeder #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .cmd_len(cmd_len),
    .mem_ren(mem_ren), .mem_radr(mem_radr), .mem_rdata(mem_rdata),
    .pe_a(pe_a), .pe_b(pe_b), .pe_awe(pe_awe), .pe_bwe(pe_bwe),
    .pe_aff(pe_aff), .pe_bff(pe_bff),
    .pe_max_cntr(pe_max_cntr), .pe_start(pe_start), .pe_fout(pe_fout),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // RAM model: data appears one cycle after the read enable.
  logic [DW-1:0] ram [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = DW'($urandom);
  end
  always @(posedge clk) if (mem_ren) mem_rdata <= ram[mem_radr];

  // Expected traffic: read addresses, and writes (A = data, B = data + 65536).
  int rd_q[$];
  int wr_q[$];
  int start_cnt = 0;
  int done_cnt  = 0;
  int exp_len   = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_ren) begin
        if (rd_q.size() == 0) check("unexpected_read", mem_radr, -1);
        else                  check("read_addr", mem_radr, rd_q.pop_front());
      end
      if (pe_awe) begin
        if (wr_q.size() == 0) check("unexpected_a_write", pe_a, -1);
        else                  check("a_write", pe_a, wr_q.pop_front());
      end
      if (pe_bwe) begin
        if (wr_q.size() == 0) check("unexpected_b_write", pe_b, -1);
        else                  check("b_write", 65536 + int'(pe_b), wr_q.pop_front());
      end
      if (pe_start) begin
        start_cnt++;
        check("start_max_cntr", pe_max_cntr, exp_len);
      end
      if (done) done_cnt++;
    end
  end

  // PE finish responder: fout high for one cycle, fout_dly cycles into WAIT_F.
  int fout_dly = 0;
  initial begin
    pe_fout = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && pe_start) begin
        @(posedge clk);
        repeat (fout_dly) @(posedge clk);
        #1 pe_fout = 1'b1;
        @(posedge clk);
        #1 pe_fout = 1'b0;
      end
    end
  end

  bit rnd_bp = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_bp) begin
      pe_aff = ($urandom_range(0, 2) == 0);
      pe_bff = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic push_exp(input int a, input int b, input int len);
    exp_len = len;
    for (int i = 0; i < len; i++) begin
      rd_q.push_back((a + i) % 4096);
      rd_q.push_back((b + i) % 4096);
      wr_q.push_back(int'(ram[(a + i) % 4096]));
      wr_q.push_back(65536 + int'(ram[(b + i) % 4096]));
    end
  endtask

  task automatic send_cmd(input int a, input int b, input int len);
    int n = 0;
    while (!cmd_ready && n < 3000) begin tick(); n++; end
    if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 1);
    push_exp(a, b, len);
    start_cnt  = 0;
    done_cnt   = 0;
    cmd_a_base = AW'(a);
    cmd_b_base = AW'(b);
    cmd_len    = CW'(len);
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done_cnt == 0 && cycles < 3000) begin tick(); cycles++; end
    if (done_cnt == 0) check("done_timeout", done_cnt, 1);
  endtask

  task automatic finish_cmd(input int len);
    int n;
    wait_done(n);
    tick();
    check("done_count", done_cnt, 1);
    check("start_count", start_cnt, (len != 0) ? 1 : 0);
    check("reads_left", rd_q.size(), 0);
    check("writes_left", wr_q.size(), 0);
    check("cmd_ready_after", cmd_ready, 1);
    check("busy_after", busy, 0);
    check("max_cntr_held", pe_max_cntr, len);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a_base = '0; cmd_b_base = '0; cmd_len = '0;
    pe_aff = 1'b0; pe_bff = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_ren", mem_ren, 0);
    check("rst_pe_start", pe_start, 0);
    check("rst_done", done, 0);
    check("rst_max_cntr", pe_max_cntr, 0);
    check("rst_pe_a", pe_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // basic transfer
    ram[12'h010] = 16'd1; ram[12'h011] = 16'd2; ram[12'h012] = 16'd3;
    ram[12'h020] = 16'd4; ram[12'h021] = 16'd5; ram[12'h022] = 16'd6;
    fout_dly = 5;
    send_cmd(12'h010, 12'h020, 3);
    finish_cmd(3);

    // backpressure on A FIFO
    ram[12'h100] = 16'h1111; ram[12'h101] = 16'h2222;
    ram[12'h200] = 16'h3333; ram[12'h201] = 16'h4444;
    fout_dly = 1;
    pe_aff = 1'b1;
    send_cmd(12'h100, 12'h200, 2);
    tick(); tick();  // RD_A -> LAT_A -> PUSH_A
    for (int i = 0; i < 10; i++) begin
      check("stall_pe_a", pe_a, 16'h1111);
      check("stall_no_read", mem_ren, 0);
      check("stall_no_awe", pe_awe, 0);
      tick();
    end
    pe_aff = 1'b0;
    finish_cmd(2);

    // zero length
    send_cmd(12'h050, 12'h060, 0);
    wait_done(n);
    check("zero_len_done_latency", (n >= 1 && n <= 2) ? 1 : 0, 1);
    tick();
    check("zero_len_done_count", done_cnt, 1);
    check("zero_len_no_start", start_cnt, 0);
    check("zero_len_max_cntr", pe_max_cntr, 0);

    // address wrap
    send_cmd(12'hFFF, 12'h300, 2);
    finish_cmd(2);

    // reset mid-operation, stalled in PUSH_B of element 1
    send_cmd(12'h400, 12'h500, 4);
    n = 0;
    while (wr_q.size() > 6 && n < 100) begin tick(); n++; end
    check("reset_setup_reached", wr_q.size(), 6);
    pe_bff = 1'b1;
    repeat (7) tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_mem_ren", mem_ren, 0);
    check("arst_awe", pe_awe, 0);
    check("arst_bwe", pe_bwe, 0);
    check("arst_pe_b", pe_b, 0);
    check("arst_max_cntr", pe_max_cntr, 0);
    check("arst_busy", busy, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_no_start", start_cnt, 0);
    rd_q.delete();
    wr_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    pe_bff = 1'b0;
    tick();
    send_cmd(12'h410, 12'h510, 1);
    finish_cmd(1);

    // command held during busy
    fout_dly = 8;
    send_cmd(12'h600, 12'h700, 1);
    n = 0;
    while (start_cnt == 0 && n < 200) begin tick(); n++; end
    check("busy_start_seen", start_cnt, 1);
    cmd_a_base = 12'h800; cmd_b_base = 12'h900; cmd_len = 8'd2; cmd_valid = 1'b1;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      check("busy_cmd_ready_low", cmd_ready, 0);
      tick();
      n++;
    end
    check("busy_first_done", done_cnt, 1);
    check("busy_first_reads_left", rd_q.size(), 0);
    check("busy_ready_in_idle", cmd_ready, 1);
    push_exp(12'h800, 12'h900, 2);
    start_cnt = 0;
    done_cnt  = 0;
    tick();
    cmd_valid = 1'b0;
    check("busy_second_accepted", busy, 1);
    finish_cmd(2);

    // maximum length
    fout_dly = 0;
    send_cmd(12'hF80, 12'h123, 255);
    finish_cmd(255);

    // randomized commands with random full flags
    rnd_bp = 1'b1;
    for (int k = 0; k < 25; k++) begin
      int a, b, len;
      a        = $urandom_range(0, 4095);
      b        = $urandom_range(0, 4095);
      len      = $urandom_range(0, 6);
      fout_dly = $urandom_range(0, 4);
      send_cmd(a, b, len);
      finish_cmd(len);
    end
    rnd_bp = 1'b0;
    pe_aff = 1'b0;
    pe_bff = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
